dma_axi_adapter: RTL and testbench
==================================

// Module: dma_axi_adapter
// PURPOSE
//  hclk-domain stage directly downstream of the SATA DMA controller. Takes one 128-byte command
//  (adp_addr/adp_type/adp_val) and runs one 16-beat x 64-bit AXI3 HP burst.
//  Memory writes take their data from the controller's to_* stream; memory reads return data
//  on its from_* stream. adp_busy reports progress back to the controller.
// PARAMETERS
//  AXI_ID    6'h0   ID driven on awid/wid/arid; bid/rid are ignored
//  AXI_CACHE 4'h3   value on awcache/arcache
//  AXI_PROT  3'h0   value on awprot/arprot
// PORTS
//  hclk          in   1   AXI-HP clock; the only clock in the block
//  rst_n         in   1   synchronous, active-low reset
//  adp_addr      in   25  [31:7] 128-byte-aligned memory address
//  adp_type      in   1   1 = memory write (SATA->mem), 0 = memory read (mem->SATA)
//  adp_val       in   1   command strobe (resynced level; may last >1 hclk)
//  adp_busy      out  1   command in progress
//  to_data       in   64  write-data stream from the controller
//  to_val        in   1   to_data valid
//  to_ack        out  1   to_data beat consumed
//  from_data     out  64  read-data stream to the controller
//  from_val      out  1   from_data valid
//  from_ack      in   1   from_data beat taken
//  axi_aw{addr,valid}/awready  out 32,1 / in 1   write address channel
//  axi_w{data,strb,last,valid}/wready  out 64,8,1,1 / in 1   write data channel
//  axi_b{valid,resp}/bready    in 1,2 / out 1    write response channel
//  axi_ar{addr,valid}/arready  out 32,1 / in 1   read address channel
//  axi_r{data,valid,resp,last}/rready  in 64,1,2,1 / out 1   read data channel
//  axi_{aw,ar}{len,size,burst} out 4,3,2  constants 4'hF, 3'h3, 2'b01 (INCR)
//  axi_{aw,ar,w}id, axi_{aw,ar}cache, axi_{aw,ar}prot  out  constants from parameters
//  err           out  1   sticky: non-OKAY resp, rlast mismatch, or command while busy
// BEHAVIOUR
//  Reset (rst_n=0 at a hclk edge): state IDLE; adp_busy, to_ack, from_val, all *valid, bready,
//   rready, err and beat counter go to 0. A burst in flight is abandoned (system-level reset only).
//  Command accept: only on the rising edge of adp_val (adp_val & ~adp_val_d) while in IDLE.
//   addr and type latch on that edge. adp_busy=1 from the next cycle.
//   A rising edge while not in IDLE is dropped and sets err.
//  FSM: IDLE -> WADDR (type 1) or RADDR (type 0).
//   WADDR: awvalid=1, awaddr={addr,7'b0}; awvalid&awready -> WDATA.
//   WDATA: wvalid=to_val, wdata=to_data, wstrb=8'hFF, wlast=(cnt==15),
//     to_ack=wvalid&wready (combinational); each handshake increments cnt; handshake with cnt==15 -> WRESP.
//   WRESP: bready=1; bvalid -> IDLE, err|=(bresp!=0).
//   RADDR: arvalid=1, araddr={addr,7'b0}; arvalid&arready -> RDATA.
//   RDATA: from_val=rvalid, from_data=rdata, rready=from_ack (no path from rready to rvalid, so no loop);
//     each handshake increments cnt; err|=(rresp!=0)|(rlast!=(cnt==15)); handshake with cnt==15 -> IDLE.
//  adp_busy=1 in every state except IDLE (registered). It falls the cycle after the final B or R handshake.
//  Latency: adp_val edge at cycle N -> awvalid/arvalid=1 at N+1. Minimum write takes 1+16+1 handshake cycles.
//  *valid stays asserted and payload stays stable until ready (AXI rule); cnt is 4-bit, cleared on accept.
//  A 128-byte aligned burst never crosses 4 KB. Address arithmetic is the upstream block's job.
// TESTING
//  T1 rst_n=0 mid-WDATA (beat 7) -> next cycle all valids/busy 0; new command then runs cleanly.
//  T2 write addr 25'h0000_021, to_val=1, ready=1 -> awaddr=32'h0000_1080; 16 beats with wlast on the 16th;
//     bresp=0 -> busy 1->0, err=0.
//  T3 read addr 25'h1FF_FFFF, random rvalid/from_ack stalls -> 16 beats in order; data matches rdata; busy falls after rlast.
//  T4 adp_val held 3 cycles -> exactly one burst; new edge while busy -> ignored, err=1.
//  T5 bresp=2'b10 on write, or rlast on beat 14 of a read -> err=1 and stays 1 until reset.
//  T6 to_val gaps (beats 3-5 absent) with wready toggling -> wvalid follows to_val; no beat lost or duplicated.

Source files
------------

// File: rtl/dma_axi_adapter.sv
// Command-to-AXI3 adapter: turns one 128-byte DMA command into a single 16x64-bit
// INCR burst, streaming write data from to_* or returning read data on from_*.
module dma_axi_adapter #(
  parameter logic [5:0] AXI_ID    = 6'h0,
  parameter logic [3:0] AXI_CACHE = 4'h3,
  parameter logic [2:0] AXI_PROT  = 3'h0
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic [24:0] adp_addr,
  input  logic        adp_type,
  input  logic        adp_val,
  output logic        adp_busy,
  input  logic [63:0] to_data,
  input  logic        to_val,
  output logic        to_ack,
  output logic [63:0] from_data,
  output logic        from_val,
  input  logic        from_ack,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [3:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic [5:0]  axi_awid,
  output logic [3:0]  axi_awcache,
  output logic [2:0]  axi_awprot,
  output logic [63:0] axi_wdata,
  output logic [7:0]  axi_wstrb,
  output logic        axi_wlast,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [5:0]  axi_wid,
  input  logic        axi_bvalid,
  input  logic [1:0]  axi_bresp,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [3:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic [5:0]  axi_arid,
  output logic [3:0]  axi_arcache,
  output logic [2:0]  axi_arprot,
  input  logic [63:0] axi_rdata,
  input  logic        axi_rvalid,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rlast,
  output logic        axi_rready,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_e;

  state_e      state_q, state_d;
  logic [24:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        val_q;
  logic        rise;
  logic        last_beat;

  // adp_val is a resynchronised level; only its rising edge is a command
  assign rise      = adp_val & ~val_q;
  assign last_beat = (cnt_q == 4'hF);

  assign axi_awaddr  = {addr_q, 7'b0};
  assign axi_araddr  = {addr_q, 7'b0};
  assign axi_awlen   = 4'hF;
  assign axi_arlen   = 4'hF;
  assign axi_awsize  = 3'h3;
  assign axi_arsize  = 3'h3;
  assign axi_awburst = 2'b01;
  assign axi_arburst = 2'b01;
  assign axi_awid    = AXI_ID;
  assign axi_arid    = AXI_ID;
  assign axi_wid     = AXI_ID;
  assign axi_awcache = AXI_CACHE;
  assign axi_arcache = AXI_CACHE;
  assign axi_awprot  = AXI_PROT;
  assign axi_arprot  = AXI_PROT;
  assign axi_wdata   = to_data;
  assign axi_wstrb   = 8'hFF;
  assign from_data   = axi_rdata;
  assign adp_busy    = (state_q != IDLE);
  assign err         = err_q;

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      val_q   <= adp_val;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    to_ack      = 1'b0;
    from_val    = 1'b0;

    if (rise && state_q != IDLE) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (rise) begin
          addr_d  = adp_addr;
          cnt_d   = '0;
          state_d = adp_type ? WADDR : RADDR;
        end
      end
      WADDR: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_d = WDATA;
      end
      WDATA: begin
        axi_wvalid = to_val;
        axi_wlast  = last_beat;
        to_ack     = to_val & axi_wready;
        if (to_val && axi_wready) begin
          cnt_d = cnt_q + 4'd1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          state_d = IDLE;
          if (axi_bresp != 2'b00) err_d = 1'b1;
        end
      end
      RADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_d = RDATA;
      end
      RDATA: begin
        // rready comes straight from the consumer; rvalid never depends on it
        from_val   = axi_rvalid;
        axi_rready = from_ack;
        if (axi_rvalid && from_ack) begin
          cnt_d = cnt_q + 4'd1;
          if ((axi_rresp != 2'b00) || (axi_rlast != last_beat)) err_d = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_axi_adapter.sv
// Bench for dma_axi_adapter: AXI slave and DMA-side models with a data scoreboard.
module tb_dma_axi_adapter;
  logic        hclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [24:0] adp_addr = '0;
  logic        adp_type = 1'b0, adp_val = 1'b0, adp_busy;
  logic [63:0] to_data = '0, from_data;
  logic        to_val = 1'b0, to_ack, from_val, from_ack = 1'b0;
  logic [31:0] axi_awaddr, axi_araddr;
  logic        axi_awvalid, axi_awready = 1'b0, axi_arvalid, axi_arready = 1'b0;
  logic [3:0]  axi_awlen, axi_arlen, axi_awcache, axi_arcache;
  logic [2:0]  axi_awsize, axi_arsize, axi_awprot, axi_arprot;
  logic [1:0]  axi_awburst, axi_arburst;
  logic [5:0]  axi_awid, axi_arid, axi_wid;
  logic [63:0] axi_wdata, axi_rdata = '0;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready = 1'b0;
  logic        axi_bvalid = 1'b0, axi_bready;
  logic [1:0]  axi_bresp = '0, axi_rresp = '0;
  logic        axi_rvalid = 1'b0, axi_rlast = 1'b0, axi_rready, err;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb[$];

  always #5 hclk = ~hclk;

  dma_axi_adapter dut (
    .hclk(hclk), .rst_n(rst_n), .adp_addr(adp_addr), .adp_type(adp_type), .adp_val(adp_val),
    .adp_busy(adp_busy), .to_data(to_data), .to_val(to_val), .to_ack(to_ack),
    .from_data(from_data), .from_val(from_val), .from_ack(from_ack),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awid(axi_awid), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wid(axi_wid),
    .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_arid(axi_arid), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rready(axi_rready), .err(err)
  );

  function automatic logic [63:0] beat_data(input int tag, input int i);
    return {32'hD000_0000 + 32'(tag), 32'(i) * 32'h0101_0101 + 32'h0F0F_0000};
  endfunction

  task automatic idle_inputs();
    adp_val = 0; to_val = 0; from_ack = 0; axi_awready = 0; axi_wready = 0;
    axi_bvalid = 0; axi_bresp = 0; axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rresp = 0;
  endtask

  task automatic test_reset();
    logic [8:0] outs;
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge hclk);
    rst_n = 1;
    #1;
    outs = {adp_busy, to_ack, from_val, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, err};
    checks++;
    if (outs !== 9'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", outs, 9'b0); end
    checks++;
    if ({axi_awlen, axi_awsize, axi_awburst, axi_awcache, axi_wstrb} !== {4'hF, 3'h3, 2'b01, 4'h3, 8'hFF}) begin
      failures++; $display("FAIL reset_consts got=%h", {axi_awlen, axi_awsize, axi_awburst, axi_awcache, axi_wstrb});
    end
    @(negedge hclk);
  endtask

  task automatic check_err(input logic exp, input string name);
    #1;
    checks++;
    if (err !== exp) begin failures++; $display("FAIL %s err got=%b exp=%b", name, err, exp); end
  endtask

  // Write burst; abort_at>=0 pulls rst_n low once that many beats have gone
  task automatic run_write(input logic [24:0] a, input int tag, input bit gap, input bit rnd,
                           input logic [1:0] br, input int val_len, input int pulse_at, input int abort_at);
    int beats, pushed, gap_cnt, cyc, aw_cnt, pulse_st;
    bit aw_done, done;
    logic [63:0] exp;
    logic [8:0] outs;
    beats = 0; pushed = 0; gap_cnt = 0; cyc = 0; aw_cnt = 0; pulse_st = 0; aw_done = 0; done = 0;
    sb.delete();
    @(negedge hclk);
    adp_addr = a; adp_type = 1; adp_val = 1;
    @(negedge hclk);
    #1;
    checks++;
    if (adp_busy !== 1'b1 || axi_awvalid !== 1'b1) begin
      failures++; $display("FAIL wr_accept busy=%b awvalid=%b exp=1", adp_busy, axi_awvalid);
    end
    checks++;
    if (axi_awaddr !== {a, 7'b0}) begin failures++; $display("FAIL wr_awaddr got=%h exp=%h", axi_awaddr, {a, 7'b0}); end
    while (!done && cyc < 400) begin
      if (abort_at >= 0 && beats == abort_at) begin
        idle_inputs();
        rst_n = 0;
        @(negedge hclk);
        #1;
        outs = {adp_busy, to_ack, from_val, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, err};
        checks++;
        if (outs !== 9'b0) begin failures++; $display("FAIL abort_reset got=%b exp=%b", outs, 9'b0); end
        rst_n = 1;
        sb.delete();
        @(negedge hclk);
        return;
      end
      adp_val = (cyc < val_len - 1);
      if (pulse_at >= 0 && pulse_st == 0 && beats == pulse_at) begin adp_val = 1; pulse_st = 1; end
      else if (pulse_st == 1) pulse_st = 2;
      axi_awready = 1;
      if (gap && beats == 3 && gap_cnt < 3) begin to_val = 0; gap_cnt++; end
      else to_val = (beats < 16);
      to_data = beat_data(tag, beats);
      if (to_val && pushed == beats) begin sb.push_back(to_data); pushed++; end
      axi_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_bvalid = (beats == 16);
      axi_bresp = br;
      #1;
      checks++;
      if (to_ack !== (axi_wvalid & axi_wready)) begin
        failures++; $display("FAIL to_ack got=%b exp=%b", to_ack, axi_wvalid & axi_wready);
      end
      if (aw_done && beats < 16) begin
        checks++;
        if (axi_wvalid !== to_val) begin failures++; $display("FAIL wvalid_follow got=%b exp=%b", axi_wvalid, to_val); end
      end
      if (axi_awvalid && axi_awready) aw_cnt++;
      if (axi_wvalid && axi_wready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hBAD;
        checks++;
        if (axi_wdata !== exp) begin failures++; $display("FAIL wdata beat=%0d got=%h exp=%h", beats, axi_wdata, exp); end
        checks++;
        if (axi_wlast !== (beats == 15)) begin failures++; $display("FAIL wlast beat=%0d got=%b exp=%b", beats, axi_wlast, beats == 15); end
        beats++;
      end
      if (axi_bvalid && axi_bready) done = 1;
      if (axi_awvalid && axi_awready) aw_done = 1;
      @(negedge hclk);
      cyc++;
    end
    idle_inputs();
    #1;
    checks++;
    if (!done) begin failures++; $display("FAIL wr_timeout beats got=%0d exp=16", beats); end
    checks++;
    if (adp_busy !== 1'b0) begin failures++; $display("FAIL wr_busy_fall got=%b exp=0", adp_busy); end
    checks++;
    if (aw_cnt != 1 || sb.size() != 0) begin failures++; $display("FAIL wr_one_burst aw=%0d left=%0d exp=1/0", aw_cnt, sb.size()); end
  endtask

  task automatic run_read(input logic [24:0] a, input int tag, input bit rnd, input int last_idx);
    int rb, pushed, cyc, ar_cnt;
    bit ar_done, done, hold;
    logic [63:0] exp;
    rb = 0; pushed = 0; cyc = 0; ar_cnt = 0; ar_done = 0; done = 0; hold = 0;
    sb.delete();
    @(negedge hclk);
    adp_addr = a; adp_type = 0; adp_val = 1;
    @(negedge hclk);
    adp_val = 0;
    #1;
    checks++;
    if (adp_busy !== 1'b1 || axi_arvalid !== 1'b1) begin
      failures++; $display("FAIL rd_accept busy=%b arvalid=%b exp=1", adp_busy, axi_arvalid);
    end
    checks++;
    if (axi_araddr !== {a, 7'b0}) begin failures++; $display("FAIL rd_araddr got=%h exp=%h", axi_araddr, {a, 7'b0}); end
    while (!done && cyc < 400) begin
      axi_arready = 1;
      if (!hold) axi_rvalid = (ar_done && rb < 16) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      axi_rdata = beat_data(tag, rb);
      axi_rlast = (rb == last_idx);
      axi_rresp = 0;
      if (axi_rvalid && pushed == rb) begin sb.push_back(axi_rdata); pushed++; end
      from_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      checks++;
      if (from_val !== axi_rvalid) begin failures++; $display("FAIL from_val got=%b exp=%b", from_val, axi_rvalid); end
      if (ar_done) begin
        checks++;
        if (axi_rready !== from_ack) begin failures++; $display("FAIL rready got=%b exp=%b", axi_rready, from_ack); end
      end
      if (axi_arvalid && axi_arready) ar_cnt++;
      hold = axi_rvalid & ~axi_rready;
      if (axi_rvalid && axi_rready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hBAD;
        checks++;
        if (from_data !== exp) begin failures++; $display("FAIL from_data beat=%0d got=%h exp=%h", rb, from_data, exp); end
        rb++;
        if (rb == 16) done = 1;
      end
      if (axi_arvalid && axi_arready) ar_done = 1;
      @(negedge hclk);
      cyc++;
    end
    idle_inputs();
    #1;
    checks++;
    if (!done) begin failures++; $display("FAIL rd_timeout beats got=%0d exp=16", rb); end
    checks++;
    if (adp_busy !== 1'b0) begin failures++; $display("FAIL rd_busy_fall got=%b exp=0", adp_busy); end
    checks++;
    if (ar_cnt != 1) begin failures++; $display("FAIL rd_one_burst got=%0d exp=1", ar_cnt); end
  endtask

  task automatic test_write_basic();
    run_write(25'h000_0021, 1, 0, 0, 2'b00, 1, -1, -1);
    checks++;
    if ({25'h000_0021, 7'b0} !== axi_awaddr) begin failures++; $display("FAIL t2_awaddr got=%h exp=%h", axi_awaddr, 32'h0000_1080); end
    check_err(1'b0, "t2_write");
  endtask

  task automatic test_read_stall();
    run_read(25'h1FF_FFFF, 2, 1, 15);
    checks++;
    if (axi_araddr !== 32'hFFFF_FF80) begin failures++; $display("FAIL t3_araddr got=%h exp=%h", axi_araddr, 32'hFFFF_FF80); end
    check_err(1'b0, "t3_read");
  endtask

  task automatic test_gaps();
    run_write(25'h012_3450, 3, 1, 1, 2'b00, 1, -1, -1);
    check_err(1'b0, "t6_gaps");
  endtask

  task automatic test_cmd_while_busy();
    run_write(25'h000_0100, 4, 0, 0, 2'b00, 3, 8, -1);
    check_err(1'b1, "t4_edge_busy");
    repeat (4) begin
      @(negedge hclk);
      #1;
      checks++;
      if ({adp_busy, axi_awvalid, axi_arvalid} !== 3'b000) begin
        failures++; $display("FAIL t4_no_second got=%b exp=000", {adp_busy, axi_awvalid, axi_arvalid});
      end
    end
  endtask

  task automatic test_err_sticky();
    test_reset();
    check_err(1'b0, "t5_cleared");
    run_write(25'h000_0200, 5, 0, 0, 2'b10, 1, -1, -1);
    check_err(1'b1, "t5_bresp");
    repeat (3) @(negedge hclk);
    check_err(1'b1, "t5_bresp_sticky");
    test_reset();
    run_read(25'h000_0300, 6, 0, 13);
    check_err(1'b1, "t5_rlast");
    repeat (3) @(negedge hclk);
    check_err(1'b1, "t5_rlast_sticky");
  endtask

  task automatic test_reset_mid_burst();
    test_reset();
    run_write(25'h000_0400, 7, 0, 0, 2'b00, 1, -1, 7);
    run_write(25'h000_0500, 8, 0, 1, 2'b00, 1, -1, -1);
    check_err(1'b0, "t1_after_reset");
  endtask

  task automatic test_back_to_back();
    run_read(25'h000_0600, 9, 0, 15);
    run_write(25'h000_0700, 10, 0, 0, 2'b00, 1, -1, -1);
    check_err(1'b0, "back_to_back");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_stall();
    test_gaps();
    test_back_to_back();
    test_cmd_while_busy();
    test_err_sticky();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
